// File: rtl/commit_trace_pkg.sv
// Shared record type for the commit trace queue: one retired instruction or one trap per record.
package commit_trace_pkg;

  localparam logic KIND_COMMIT = 1'b0;
  localparam logic KIND_TRAP   = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic        wfp;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] cause;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/commit_trace_packer.sv
// Compacts sparse commit lanes plus an optional trap into dense records, oldest first,
// and reports how many slots are occupied.
import commit_trace_pkg::*;

module commit_trace_packer #(
  parameter  int COMMITS = 2,
  localparam int NW      = $clog2(COMMITS + 2)
) (
  input  logic [COMMITS-1:0]    valid_i,
  input  logic [COMMITS*64-1:0] pc_i,
  input  logic [COMMITS*32-1:0] insn_i,
  input  logic [COMMITS-1:0]    wen_i,
  input  logic [COMMITS-1:0]    wfp_i,
  input  logic [COMMITS*5-1:0]  waddr_i,
  input  logic [COMMITS*64-1:0] wdata_i,
  input  logic                  trap_valid_i,
  input  logic [63:0]           trap_cause_i,
  output commit_rec_t [COMMITS:0] slots_o,
  output logic [NW-1:0]         n_o
);

  commit_rec_t [COMMITS-1:0] lane_rec;
  commit_rec_t               trap_rec;
  logic [NW-1:0]             idx;

  // Lanes that do not write a register carry zero destination fields.
  for (genvar gi = 0; gi < COMMITS; gi++) begin : g_lane
    assign lane_rec[gi] = '{
      kind:  KIND_COMMIT,
      pc:    pc_i[gi*64 +: 64],
      insn:  insn_i[gi*32 +: 32],
      wen:   wen_i[gi],
      wfp:   wfp_i[gi],
      waddr: wen_i[gi] ? waddr_i[gi*5 +: 5] : 5'd0,
      wdata: wen_i[gi] ? wdata_i[gi*64 +: 64] : 64'd0,
      cause: 64'd0
    };
  end

  assign trap_rec = '{kind: KIND_TRAP, pc: 64'd0, insn: 32'd0, wen: 1'b0, wfp: 1'b0,
                      waddr: 5'd0, wdata: 64'd0, cause: trap_cause_i};

  always_comb begin
    slots_o = '0;
    idx     = '0;
    for (int i = 0; i < COMMITS; i++) begin
      if (valid_i[i]) begin
        slots_o[idx] = lane_rec[i];
        idx          = idx + 1'b1;
      end
    end
    if (trap_valid_i) begin
      slots_o[idx] = trap_rec;
      idx          = idx + 1'b1;
    end
    n_o = idx;
  end

endmodule

// File: rtl/commit_trace_queue.sv
// Multi-wide retirement trace FIFO draining one record per cycle to the difftest checker.
// Optional watchdog (sticky hang flag) is enabled by defining COMMIT_TRACE_TIMEOUT_EN.
import commit_trace_pkg::*;

module commit_trace_queue #(
  parameter int HARTID     = 0,
  parameter int COMMITS    = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [COMMITS-1:0]    in_valid,
  input  logic [COMMITS*64-1:0] in_pc,
  input  logic [COMMITS*32-1:0] in_insn,
  input  logic [COMMITS-1:0]    in_wen,
  input  logic [COMMITS-1:0]    in_wfp,
  input  logic [COMMITS*5-1:0]  in_waddr,
  input  logic [COMMITS*64-1:0] in_wdata,
  input  logic                  trap_valid,
  input  logic [63:0]           trap_cause,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_kind,
  output logic [31:0]           out_hartid,
  output logic [63:0]           out_pc,
  output logic [31:0]           out_insn,
  output logic                  out_wen,
  output logic                  out_wfp,
  output logic [4:0]            out_waddr,
  output logic [63:0]           out_wdata,
  output logic [63:0]           out_cause,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  hang
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int NW    = $clog2(COMMITS + 2);

  commit_rec_t [COMMITS:0] slots;
  logic [NW-1:0]           n;
  commit_rec_t             mem_q [DEPTH];
  commit_rec_t             head;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           occ, free;
  logic                    accept, deq, overflow_q;

  commit_trace_packer #(.COMMITS(COMMITS)) u_packer (
    .valid_i      (in_valid),
    .pc_i         (in_pc),
    .insn_i       (in_insn),
    .wen_i        (in_wen),
    .wfp_i        (in_wfp),
    .waddr_i      (in_waddr),
    .wdata_i      (in_wdata),
    .trap_valid_i (trap_valid),
    .trap_cause_i (trap_cause),
    .slots_o      (slots),
    .n_o          (n)
  );

  // Admission uses start-of-cycle occupancy only; a same-cycle pop does not make room.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign free     = PW'(DEPTH) - occ;
  assign accept   = (n != '0) && (PW'(n) <= free);
  assign deq      = (occ != '0) && out_ready;
  assign wr_ptr_d = accept ? wr_ptr_q + PW'(n) : wr_ptr_q;
  assign rd_ptr_d = rd_ptr_q + PW'(deq);

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i <= COMMITS; i++) begin
        if (i < int'(n)) begin
          mem_q[wr_ptr_q[DEPTH_LOG2-1:0] + DEPTH_LOG2'(i)] <= slots[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if ((n != '0) && !accept) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Stale storage is masked so an empty queue presents all-zero data.
  assign head       = (occ != '0) ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : '0;
  assign out_valid  = (occ != '0);
  assign out_kind   = head.kind;
  assign out_hartid = 32'(HARTID);
  assign out_pc     = head.pc;
  assign out_insn   = head.insn;
  assign out_wen    = head.wen;
  assign out_wfp    = head.wfp;
  assign out_waddr  = head.waddr;
  assign out_wdata  = head.wdata;
  assign out_cause  = head.cause;
  assign count      = occ;
  assign overflow   = overflow_q;

`ifdef COMMIT_TRACE_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        hang_q;

  assign wdog_d = (accept && (in_valid != '0)) ? 32'd0 :
                  (wdog_q == 32'hFFFF_FFFF)    ? wdog_q : wdog_q + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q <= '0;
      hang_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (wdog_d >= 32'(TIMEOUT)) begin
        hang_q <= 1'b1;
      end
    end
  end

  assign hang = hang_q;
`else
  // Watchdog compiled out; TIMEOUT is non-negative so this is constant 0.
  assign hang = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_commit_trace_queue.sv
// Scoreboard bench for commit_trace_queue: a driver pushes expected records, a monitor checks the drain.
import commit_trace_pkg::*;

module tb_commit_trace_queue;

  localparam int C     = 2;
  localparam int DEPTH = 16;
`ifdef COMMIT_TRACE_TIMEOUT_EN
  localparam bit HANG_EN = 1'b1;
`else
  localparam bit HANG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [C-1:0]  in_valid = '0;
  logic [C*64-1:0] in_pc = '0;
  logic [C*32-1:0] in_insn = '0;
  logic [C-1:0]  in_wen = '0;
  logic [C-1:0]  in_wfp = '0;
  logic [C*5-1:0]  in_waddr = '0;
  logic [C*64-1:0] in_wdata = '0;
  logic          trap_valid = 1'b0;
  logic [63:0]   trap_cause = '0;
  logic          out_valid, out_ready = 1'b0, out_kind, out_wen, out_wfp, overflow, hang;
  logic [31:0]   out_hartid, out_insn;
  logic [63:0]   out_pc, out_wdata, out_cause;
  logic [4:0]    out_waddr;
  logic [4:0]    count;

  int errors = 0;
  int checks = 0;
  commit_rec_t sb[$];
  int  mdl_count = 0;
  bit  mdl_ovf = 1'b0;
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;

  commit_trace_queue #(.HARTID(0), .COMMITS(C), .DEPTH_LOG2(4), .TIMEOUT(8)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn),
    .in_wen(in_wen), .in_wfp(in_wfp), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_hartid(out_hartid), .out_pc(out_pc),
    .out_insn(out_insn), .out_wen(out_wen), .out_wfp(out_wfp), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .out_cause(out_cause), .count(count), .overflow(overflow),
    .hang(hang)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the negedge; at the following posedge apply the reference rules.
  task automatic step(input logic [C-1:0] v, input logic t, input logic rdy,
                      input logic [63:0] pc0, input logic [63:0] pc1, input logic [63:0] cause);
    commit_rec_t items[$];
    commit_rec_t r;
    logic [63:0] pcs [C];
    int cnt0;
    pcs[0] = pc0;
    pcs[1] = pc1;
    @(negedge clk);
    in_valid   = v;
    trap_valid = t;
    trap_cause = cause;
    out_ready  = rdy;
    for (int i = 0; i < C; i++) begin
      in_pc[i*64 +: 64]   = pcs[i];
      in_insn[i*32 +: 32] = $urandom;
      in_wen[i]           = 1'($urandom_range(0, 1));
      in_wfp[i]           = 1'($urandom_range(0, 1));
      in_waddr[i*5 +: 5]  = 5'($urandom_range(0, 31));
      in_wdata[i*64 +: 64] = {$urandom, $urandom};
      if (v[i]) begin
        r       = '0;
        r.kind  = 1'b0;
        r.pc    = pcs[i];
        r.insn  = in_insn[i*32 +: 32];
        r.wen   = in_wen[i];
        r.wfp   = in_wfp[i];
        if (in_wen[i]) begin
          r.waddr = in_waddr[i*5 +: 5];
          r.wdata = in_wdata[i*64 +: 64];
        end
        items.push_back(r);
      end
    end
    if (t) begin
      r       = '0;
      r.kind  = 1'b1;
      r.cause = cause;
      items.push_back(r);
    end
    @(posedge clk);
    cnt0 = mdl_count;
    if (items.size() != 0) begin
      if (items.size() <= DEPTH - cnt0) begin
        foreach (items[k]) sb.push_back(items[k]);
        mdl_count += items.size();
      end else begin
        mdl_ovf = 1'b1;
      end
    end
    if (cnt0 != 0 && rdy) mdl_count--;
  endtask

  task automatic idle(input logic rdy, input int cycles);
    for (int i = 0; i < cycles; i++) step('0, 1'b0, rdy, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = '0;
    trap_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    sb.delete();
    mdl_count = 0;
    mdl_ovf = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_hang", hang, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_cause", out_cause, 0);
    chk("rst_out_kind", out_kind, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: sample between the driver's negedge update and the next active edge.
  initial begin
    commit_rec_t act, exp;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && !reset) begin
        chk("count", count, sb.size());
        chk("out_valid", out_valid, sb.size() != 0);
        chk("overflow", overflow, mdl_ovf);
        chk("hartid", out_hartid, 0);
        if (out_valid && out_ready) begin
          act = '{kind: out_kind, pc: out_pc, insn: out_insn, wen: out_wen, wfp: out_wfp,
                  waddr: out_waddr, wdata: out_wdata, cause: out_cause};
          if (sb.size() == 0) begin
            chk("unexpected_record", act, 0);
          end else begin
            exp = sb.pop_front();
            chk("record", act, exp);
          end
        end
      end
    end
  end

  initial begin
    do_reset();
    mon_en = 1'b1;

    // Two lanes in one cycle drain in lane order.
    step(2'b11, 1'b0, 1'b1, 64'h8000_0000, 64'h8000_0004, 64'd0);
    idle(1'b1, 4);

    // Gap on lane 0 plus trap: commit then trap record.
    step(2'b10, 1'b1, 1'b1, 64'd0, 64'h8000_0010, 64'h2);
    idle(1'b1, 4);

    // Fill to 16, ninth cycle dropped, contents intact.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(2'b11, 1'b0, 1'b0, 64'h1000 + 64'(i*8), 64'h1004 + 64'(i*8), 64'd0);
    step(2'b11, 1'b0, 1'b0, 64'hdead_0000, 64'hdead_0004, 64'd0);
    #1;
    chk("full_count", count, 16);
    chk("full_overflow", overflow, 1);
    idle(1'b1, 20);

    // count=15 with a pop and N=2 in the same cycle: rejected, count drops to 14.
    do_reset();
    for (int i = 0; i < 7; i++)
      step(2'b11, 1'b0, 1'b0, 64'h2000 + 64'(i*8), 64'h2004 + 64'(i*8), 64'd0);
    step(2'b01, 1'b0, 1'b0, 64'h2100, 64'd0, 64'd0);
    step(2'b11, 1'b0, 1'b1, 64'h2200, 64'h2204, 64'd0);
    #1;
    chk("no_credit_count", count, 14);
    chk("no_credit_overflow", overflow, 1);
    idle(1'b1, 20);

    // 20 records with ready toggling, then drain across the pointer wrap.
    do_reset();
    for (int i = 0; i < 10; i++)
      step(2'b11, 1'b0, 1'(i % 2 == 0), 64'h3000 + 64'(i*8), 64'h3004 + 64'(i*8), 64'd0);
    idle(1'b1, 24);

    // Randomized traffic with periodic resets.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int i = 0; i < 500; i++)
        step(C'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 3) != (blk == 0 ? 0 : 3) ? 1 : 0),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      idle(1'b1, 24);
    end
    chk("final_count", count, 0);

    // Watchdog: quiet for TIMEOUT cycles after reset.
    do_reset();
    mon_en = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("hang_before", hang, 0);
    @(posedge clk);
    #1;
    chk("hang_after", hang, HANG_EN);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
